// File: rtl/fib_seq_detector.sv
// fib_seq_detector: stream stage that walks the Fibonacci sequence to classify an operand
module fib_seq_detector #(
  parameter int N     = 16,
  parameter int IDX_W = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out,
  output logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] hit_cnt
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  function automatic int max_idx();
    logic [N+1:0] a, b, t;
    int k;
    a = '0;
    b = 1;
    k = 0;
    for (int i = 0; i < 256; i++)
      if (a < {2'b00, {N{1'b1}}}) begin
        t = a + b;
        a = b;
        b = t;
        k++;
      end
    return k;
  endfunction
  if ((1 << IDX_W) <= max_idx()) begin : g_idx_w_check
    $error("IDX_W too small for N");
  end
  state_t           state;
  logic [N-1:0]     operand;
  logic [N+1:0]     a, b;
  logic [IDX_W-1:0] k;
  logic [N+1:0]     op_ext;
  assign op_ext    = {2'b00, operand};
  assign in_ready  = (state == IDLE) & !rst;
  assign out_valid = (state == DONE);
  // accept operand, step one Fibonacci term per cycle, hold result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      operand <= '0;
      a       <= '0;
      b       <= '0;
      k       <= '0;
      out     <= 1'b0;
      idx     <= '0;
      hit_cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (in_valid) begin
            operand <= in;
            a       <= '0;
            b       <= 1;
            k       <= '0;
            state   <= SEARCH;
          end
        SEARCH:
          if (a >= op_ext) begin
            out   <= (a == op_ext);
            idx   <= k;
            state <= DONE;
          end else begin
            a <= b;
            b <= a + b;
            k <= k + 1'b1;
          end
        DONE:
          if (out_ready) begin
            state <= IDLE;
            if (out && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_seq_detector.sv
// tb_fib_seq_detector: randomized and directed checks against a Fibonacci-list reference model
module tb_fib_seq_detector;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst;
  logic [1:0] in_valid, in_ready, out_valid, out_ready, out;
  logic [15:0] din_a;
  logic [7:0]  din_b;
  logic [5:0]  idx [2];
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;
  int n_tests = 0, n_fail = 0;
  int exp_cnt [2] = '{0, 0};
  int cnt_max [2] = '{255, 3};
  fib_seq_detector #(.N(16), .IDX_W(6), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in(din_a),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out[0]), .idx(idx[0]), .hit_cnt(cnt_a)
  );
  fib_seq_detector #(.N(8), .IDX_W(6), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in(din_b),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out[1]), .idx(idx[1]), .hit_cnt(cnt_b)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  // reference: list Fibonacci numbers until one reaches v, then find the first F(k) >= v
  function automatic void model(input int v, output int hit, output int k);
    int f[$];
    f = '{0, 1};
    while (f[f.size()-1] < v) f.push_back(f[f.size()-1] + f[f.size()-2]);
    k = 0;
    while (f[k] < v) k++;
    hit = (f[k] == v) ? 1 : 0;
  endfunction
  function automatic int hc(input int s);
    return (s == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction
  task automatic drive_in(input int s, input int v);
    if (s == 0) din_a = v[15:0];
    else din_b = v[7:0];
  endtask
  task automatic transact(input int s, input int v, input int hold, output int r_out, output int r_idx);
    int hit, k, lat;
    bit got;
    model(v, hit, k);
    r_out = -1;
    r_idx = -1;
    lat = 0;
    while (!in_ready[s] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("in_ready_wait", int'(in_ready[s]), 1);
    drive_in(s, v);
    in_valid[s]  = 1'b1;
    out_ready[s] = (hold == 0);
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    drive_in(s, int'($urandom));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      got = out_valid[s];
    end
    chk("done_timeout", int'(got), 1);
    if (!got) return;
    chk("out", int'(out[s]), hit);
    chk("idx", int'(idx[s]), k);
    chk("latency", lat, k + 1);
    r_out = int'(out[s]);
    r_idx = int'(idx[s]);
    if (hold > 0) begin
      in_valid[s] = 1'b1;
      drive_in(s, v ^ 5);
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_valid", int'(out_valid[s]), 1);
        chk("hold_out", int'(out[s]), hit);
        chk("hold_idx", int'(idx[s]), k);
        chk("hold_in_ready", int'(in_ready[s]), 0);
      end
      out_ready[s] = 1'b1;
      @(posedge clk); #1;
      in_valid[s] = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    out_ready[s] = 1'b0;
    if (hit == 1 && exp_cnt[s] < cnt_max[s]) exp_cnt[s]++;
    chk("handoff_valid", int'(out_valid[s]), 0);
    chk("post_in_ready", int'(in_ready[s]), 1);
    chk("hit_cnt", hc(s), exp_cnt[s]);
  endtask
  initial begin
    int ro, ri, v;
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    int sat_in  [5] = '{2, 3, 5, 8, 13};
    int fibs    [8] = '{21, 34, 55, 89, 144, 987, 28657, 46368};
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    din_a = '0;
    din_b = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_out_valid", int'(out_valid[s]), 0);
      chk("rst_out", int'(out[s]), 0);
      chk("rst_idx", int'(idx[s]), 0);
      chk("rst_hit_cnt", hc(s), 0);
      chk("rst_in_ready", int'(in_ready[s]), 0);
    end
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", int'(in_ready[0]), 1);
    transact(0, 13, 0, ro, ri);
    chk("d13_out", ro, 1);
    chk("d13_idx", ri, 7);
    chk("d13_cnt", int'(cnt_a), 1);
    transact(0, 4, 0, ro, ri);
    chk("d4_idx", ri, 5);
    transact(0, 0, 0, ro, ri);
    chk("d0_idx", ri, 0);
    transact(0, 1, 0, ro, ri);
    chk("d1_idx", ri, 1);
    chk("d_cnt3", int'(cnt_a), 3);
    transact(0, 46368, 0, ro, ri);
    chk("d46368_out", ro, 1);
    chk("d46368_idx", ri, 24);
    transact(0, 65535, 0, ro, ri);
    chk("d65535_out", ro, 0);
    chk("d65535_idx", ri, 25);
    transact(0, 8, 5, ro, ri);
    chk("d8_idx", ri, 6);
    in_valid[0] = 1'b1;
    din_a = 16'd6765;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_mid_search", int'(out_valid[0]), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready_rst", int'(in_ready[0]), 0);
    chk("abort_hit_cnt", int'(cnt_a), 0);
    rst = 1'b0;
    out_ready[0] = 1'b0;
    exp_cnt = '{0, 0};
    #1;
    chk("abort_out_valid", int'(out_valid[0]), 0);
    chk("abort_in_ready_after", int'(in_ready[0]), 1);
    transact(0, 6765, 0, ro, ri);
    chk("d6765_out", ro, 1);
    chk("d6765_idx", ri, 20);
    for (int i = 0; i < 30; i++) begin
      v = (i % 3 == 0) ? fibs[$urandom_range(0, 7)] : int'($urandom_range(0, 65535));
      transact(0, v, int'($urandom_range(0, 3)), ro, ri);
    end
    for (int i = 0; i < 5; i++) begin
      transact(1, sat_in[i], 0, ro, ri);
      chk("sat_cnt", int'(cnt_b), sat_exp[i]);
    end
    for (int i = 0; i < 256; i++) transact(1, i, 0, ro, ri);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
